// File: rtl/ntt_ctrl.sv
// ntt_ctrl
// Sequencer for one Kyber butterfly unit working on a 256-coefficient polynomial held in
// dual-port RAM. It runs either a forward NTT (7 Cooley-Tukey layers, len 128 -> 2) or an
// inverse NTT (7 Gentleman-Sande layers, len 2 -> 128). Each issue slot it drives the two RAM
// read addresses, the twiddle ROM index and the butterfly mode. The write-back strobe and
// addresses are the read strobe and addresses delayed by the read+butterfly latency.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous reset, active high
//   i_start      start request, sampled only in IDLE
//   i_inv        0 = NTT, 1 = INTT, captured in the start-accept cycle
//   o_busy       high from the cycle after start is accepted until the done cycle
//   o_done       one-cycle pulse, the cycle after the last write-back
//   o_rd_en      butterfly issue strobe (read operands a and b)
//   o_rd_addr_a  operand a address
//   o_rd_addr_b  operand b address (always o_rd_addr_a + len)
//   o_tw_addr    twiddle ROM index
//   o_bf_mode    00 NTT, 01 INTT, 11 idle (while no butterfly is in flight)
//   o_wr_en      write-back strobe (c -> wr_addr_a, d -> wr_addr_b)
//   o_wr_addr_a  o_rd_addr_a delayed BF_LAT cycles
//   o_wr_addr_b  o_rd_addr_b delayed BF_LAT cycles
//   o_state      current FSM state, for debug/checkers
//
// Handshake: o_rd_en and o_wr_en are pure strobes with no backpressure. The RAM and butterfly
// must accept one operation per cycle while the strobe is high; addresses are meaningful only
// in cycles where the matching strobe is high (they are driven to 0 otherwise on the read side).
module ntt_ctrl #(
    parameter int N      = 256,
    parameter int AW     = 8,
    parameter int TW     = 7,
    parameter int BF_LAT = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_inv,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr_a,
    output logic [AW-1:0] o_rd_addr_b,
    output logic [TW-1:0] o_tw_addr,
    output logic [1:0]    o_bf_mode,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr_a,
    output logic [AW-1:0] o_wr_addr_b,
    output logic [1:0]    o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int IW = AW - 1;                  // butterfly index width (N/2 per layer)
    localparam int LW = 3;                       // layer counter width
    localparam int DW = $clog2(BF_LAT + 1);      // drain counter width
    localparam logic [IW-1:0] I_LAST = '1;
    localparam logic [LW-1:0] L_LAST = 3'd6;
    localparam logic [DW-1:0] D_LAST = DW'(BF_LAT - 1);

    state_t          r_state;
    logic [LW-1:0]   r_l;
    logic [IW-1:0]   r_i;
    logic [DW-1:0]   r_dcnt;
    logic            r_inv;
    logic            r_busy;
    logic            r_done;
    logic            r_rd_en;
    logic [AW-1:0]   r_rd_a;
    logic [AW-1:0]   r_rd_b;
    logic [TW-1:0]   r_tw;
    logic [BF_LAT-1:0] r_dly_en;
    logic [AW-1:0]   r_dly_a [BF_LAT];
    logic [AW-1:0]   r_dly_b [BF_LAT];

    state_t          w_nxt_state;
    logic [LW-1:0]   w_nxt_l;
    logic [IW-1:0]   w_nxt_i;
    logic [DW-1:0]   w_nxt_d;
    logic            w_nxt_inv;
    logic            w_issue;

    logic [AW-1:0]   w_len;
    logic [AW-1:0]   w_idx;
    logic [AW-1:0]   w_off;
    logic [AW-1:0]   w_base;
    logic [AW-1:0]   w_a;
    logic [AW-1:0]   w_b;
    logic [IW-1:0]   w_grp;
    logic [TW-1:0]   w_tw;

    // Next state and counters. The registered read outputs describe the butterfly (r_l, r_i)
    // issued in the current cycle, so the addresses are computed from the next counter values.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_l     = r_l;
        w_nxt_i     = r_i;
        w_nxt_d     = r_dcnt;
        w_nxt_inv   = r_inv;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_nxt_state = S_RUN;
                    w_nxt_l     = '0;
                    w_nxt_i     = '0;
                    w_nxt_inv   = i_inv;
                    w_issue     = 1'b1;
                end
            end
            S_RUN: begin
                if (r_i == I_LAST) begin
                    w_nxt_state = S_DRAIN;
                    w_nxt_i     = '0;
                    w_nxt_d     = '0;
                end else begin
                    w_nxt_i = r_i + 1'b1;
                    w_issue = 1'b1;
                end
            end
            S_DRAIN: begin
                // Wait until the layer's last write-back has been issued before the next
                // layer reads, so no read can see a stale coefficient.
                if (r_dcnt == D_LAST) begin
                    if (r_l == L_LAST) begin
                        w_nxt_state = S_DONE;
                    end else begin
                        w_nxt_state = S_RUN;
                        w_nxt_l     = r_l + 1'b1;
                        w_issue     = 1'b1;
                    end
                end else begin
                    w_nxt_d = r_dcnt + 1'b1;
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // Butterfly addressing with shifts and masks only. len is a power of two, so
    // i / len is a right shift and i % len is a mask with len-1.
    always_comb begin
        w_idx = {1'b0, w_nxt_i};
        if (!w_nxt_inv) begin
            w_len  = AW'(N / 2) >> w_nxt_l;
            w_grp  = w_nxt_i >> (3'd7 - w_nxt_l);
            w_base = {1'b0, w_grp} << (4'd8 - {1'b0, w_nxt_l});
            w_tw   = (TW'(1) << w_nxt_l) + w_grp;
        end else begin
            w_len  = AW'(2) << w_nxt_l;
            w_grp  = w_nxt_i >> (w_nxt_l + 3'd1);
            w_base = {1'b0, w_grp} << ({1'b0, w_nxt_l} + 4'd2);
            // (128 >> L) - 1 is the all-ones 7-bit value shifted right by L.
            w_tw   = ({TW{1'b1}} >> w_nxt_l) - w_grp;
        end
        w_off = w_idx & (w_len - 1'b1);
        w_a   = w_base | w_off;
        w_b   = w_a + w_len;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_l      <= '0;
            r_i      <= '0;
            r_dcnt   <= '0;
            r_inv    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rd_en  <= 1'b0;
            r_rd_a   <= '0;
            r_rd_b   <= '0;
            r_tw     <= '0;
            r_dly_en <= '0;
            for (int k = 0; k < BF_LAT; k++) begin
                r_dly_a[k] <= '0;
                r_dly_b[k] <= '0;
            end
        end else begin
            r_state  <= w_nxt_state;
            r_l      <= w_nxt_l;
            r_i      <= w_nxt_i;
            r_dcnt   <= w_nxt_d;
            r_inv    <= w_nxt_inv;
            r_busy   <= (w_nxt_state == S_RUN) || (w_nxt_state == S_DRAIN);
            r_done   <= (w_nxt_state == S_DONE);
            r_rd_en  <= w_issue;
            r_rd_a   <= w_issue ? w_a  : '0;
            r_rd_b   <= w_issue ? w_b  : '0;
            r_tw     <= w_issue ? w_tw : '0;
            // Write-back delay line matching the RAM read + butterfly pipeline.
            r_dly_en   <= {r_dly_en[BF_LAT-2:0], r_rd_en};
            r_dly_a[0] <= r_rd_a;
            r_dly_b[0] <= r_rd_b;
            for (int k = 1; k < BF_LAT; k++) begin
                r_dly_a[k] <= r_dly_a[k-1];
                r_dly_b[k] <= r_dly_b[k-1];
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr_a = r_rd_a;
    assign o_rd_addr_b = r_rd_b;
    assign o_tw_addr   = r_tw;
    // The butterfly keeps its mode while any operation is between read and write-back.
    assign o_bf_mode   = (r_rd_en || (|r_dly_en)) ? {1'b0, r_inv} : 2'b11;
    assign o_wr_en     = r_dly_en[BF_LAT-1];
    assign o_wr_addr_a = r_dly_a[BF_LAT-1];
    assign o_wr_addr_b = r_dly_b[BF_LAT-1];
    assign o_state     = r_state;

endmodule
